ln_int_e: RTL



---
 rtl/ln_int_e_pkg.sv | 25 ++
 rtl/ln_int_e_if.sv | 17 +
 rtl/ln_int_e_mulfp.sv | 81 ++++++++
 rtl/ln_int_e.sv | 103 ++++++++++
 4 files changed

// File: rtl/ln_int_e_pkg.sv
// ln_int_e_pkg: shared constants and types for the ln_int_e block.
//   - FSM state encoding (3-bit; codes 6 and 7 are unused)
//   - IEEE-754 single constants: e, 1/e, 1.0
//   - IEEE single field widths and result-count width
package ln_int_e_pkg;

  localparam int unsigned FP_W  = 32;
  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam int unsigned NW    = 7;   // floor(ln(FLT_MAX)) = 88 fits

  localparam logic [FP_W-1:0] E_CONST = 32'h402DF854;  // e, loop-exit threshold
  localparam logic [FP_W-1:0] INV_E   = 32'h3EBC5AB2;  // 1/e, per-iteration factor
  localparam logic [FP_W-1:0] ONE     = 32'h3F800000;  // 1.0

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    MUL   = 3'd3,
    WAIT  = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/ln_int_e_if.sv
// ln_int_e_if: operand/result bundle for ln_int_e.
//   master: drives start/in, observes state/done/err/n/out
//   slave : the ln_int_e block
interface ln_int_e_if;
  import ln_int_e_pkg::*;

  logic          start;
  logic [31:0]   in;
  logic [2:0]    state;
  logic          done;
  logic          err;
  logic [NW-1:0] n;
  logic [31:0]   out;

  modport master (output start, in, input  state, done, err, n, out);
  modport slave  (input  start, in, output state, done, err, n, out);
endinterface

// File: rtl/ln_int_e_mulfp.sv
// mulFP: IEEE-754 single multiplier, round-to-nearest-even, two cycles after
// reset is released. Denormal operands/results flush to zero; overflow gives Inf.
//   clk     : clock
//   a, b    : operands, must be held stable while reset is low
//   result  : rounded product, valid while done=1
//   product : raw 48-bit mantissa product
//   done    : high once result is valid, held until reset
//   reset   : synchronous, active-high; restarts the multiplication
module mulFP (
  input  logic        clk,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic [47:0] product,
  output logic        done,
  input  logic        reset
);

  logic               r_vld;
  logic               r_sign;
  logic               r_zero;
  logic signed [9:0]  r_exp;
  logic [47:0]        r_prod;

  logic [22:0]        w_mant;
  logic               w_guard;
  logic               w_sticky;
  logic               w_rnd;
  logic [23:0]        w_mant_r;
  logic signed [9:0]  w_exp;
  logic [31:0]        w_res;

  // Normalise the 1.x * 1.x product (in [1,4)), then round to nearest even.
  always_comb begin
    if (r_prod[47]) begin
      w_mant   = r_prod[46:24];
      w_guard  = r_prod[23];
      w_sticky = |r_prod[22:0];
      w_exp    = r_exp + 10'sd1;
    end else begin
      w_mant   = r_prod[45:23];
      w_guard  = r_prod[22];
      w_sticky = |r_prod[21:0];
      w_exp    = r_exp;
    end
    w_rnd    = w_guard & (w_sticky | w_mant[0]);
    w_mant_r = {1'b0, w_mant} + {23'd0, w_rnd};
    // Rounding carry out: mantissa wrapped to zero, bump exponent.
    if (w_mant_r[23]) w_exp = w_exp + 10'sd1;
    if (r_zero || w_exp <= 10'sd0)
      w_res = {r_sign, 31'd0};
    else if (w_exp >= 10'sd255)
      w_res = {r_sign, 8'hFF, 23'd0};
    else
      w_res = {r_sign, w_exp[7:0], w_mant_r[22:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld  <= 1'b0;
      r_sign <= 1'b0;
      r_zero <= 1'b0;
      r_exp  <= '0;
      r_prod <= '0;
      result <= '0;
      done   <= 1'b0;
    end else if (!r_vld) begin
      r_vld  <= 1'b1;
      r_sign <= a[31] ^ b[31];
      r_zero <= (a[30:23] == 8'd0) | (b[30:23] == 8'd0);
      r_exp  <= $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
      r_prod <= {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    end else if (!done) begin
      result <= w_res;
      done   <= 1'b1;
    end
  end

  assign product = r_prod;

endmodule

// File: rtl/ln_int_e.sv
// ln_int_e: n = floor(ln x) and residual x*e^-n in [1, e) for positive IEEE single x,
// by repeated multiplication with 1/e until the accumulator drops below e.
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : ln_int_e_if.slave
//           start/in  - request and operand (latched in LOAD)
//           state     - current FSM state (debug)
//           done/err  - result valid / input invalid (only in DONE)
//           n/out     - count and residual, zero unless done (and zero on err)
module ln_int_e
  import ln_int_e_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  ln_int_e_if.slave  bus
);

  state_t        r_state;
  state_t        w_next;
  logic [31:0]   r_acc;
  logic [NW-1:0] r_cnt;
  logic          r_err;

  logic [31:0]   w_prod;
  logic [47:0]   w_mprod_unused;
  logic          w_mul_done;
  logic          w_mul_rst;
  logic          w_in_bad;
  logic          w_below_e;

  // Negative, Inf/NaN, or below 1.0 (covers zeros and denormals).
  assign w_in_bad  = bus.in[31] | (bus.in[30:23] == 8'hFF) | (bus.in < ONE);
  // Positive floats order like their magnitude bits as unsigned integers.
  assign w_below_e = r_acc[30:0] < E_CONST[30:0];
  // Multiplier runs only in MUL/WAIT; reset also clears it in the same cycle.
  assign w_mul_rst = reset | !((r_state == MUL) || (r_state == WAIT));

  mulFP u_mul (
    .clk     (clk),
    .a       (r_acc),
    .b       (INV_E),
    .result  (w_prod),
    .product (w_mprod_unused),
    .done    (w_mul_done),
    .reset   (w_mul_rst)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = bus.start ? LOAD : IDLE;
      LOAD:    w_next = w_in_bad ? DONE : CHECK;
      CHECK:   w_next = w_below_e ? DONE : MUL;
      MUL:     w_next = WAIT;
      WAIT:    w_next = w_mul_done ? CHECK : WAIT;
      DONE:    w_next = bus.start ? LOAD : DONE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          r_acc <= bus.in;
          r_cnt <= '0;
          r_err <= w_in_bad;
        end
        WAIT: begin
          if (w_mul_done) begin
            r_acc <= w_prod;
            r_cnt <= r_cnt + NW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.state = r_state;
    bus.done  = 1'b0;
    bus.err   = 1'b0;
    bus.n     = '0;
    bus.out   = '0;
    if (r_state == DONE) begin
      bus.done = 1'b1;
      bus.err  = r_err;
      bus.n    = r_err ? '0 : r_cnt;
      bus.out  = r_err ? '0 : r_acc;
    end
  end

endmodule
